tl_a_get_repeater: RTL and testbench

One-entry TileLink A-channel repeat buffer for the 8-byte-beat crossbar edge. It accepts a single A beat and re-presents it downstream as many times as the transfer needs. A multi-beat Get (size > 3) is emitted as one beat per 8 bytes, with the address incrementing and the mask forced to 0xff. The block sits directly upstream of the repeater protocol checker: that checker consumes `full` and `deq_mask` and requires `deq_mask == 8'hff` whenever `full` is high outside reset.

---
 rtl/tl_a_get_repeater.sv | 118 +++++++++++
 tb/tb_tl_a_get_repeater.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tl_a_get_repeater.sv
// One-entry TileLink A-channel repeat buffer: expands a multi-beat Get into one 8-byte beat per cycle.
// Latency: first beat is combinational pass-through; each replay follows one cycle later per deq_ready.
// Backpressure: enq_ready follows deq_ready when idle and is held low while a saved Get is replayed.
module tl_a_get_repeater #(
  parameter int ADDR_W     = 32,
  parameter int SRC_W      = 4,
  parameter int MAX_LGSIZE = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [2:0]        enq_opcode,
  input  logic [2:0]        enq_param,
  input  logic [2:0]        enq_size,
  input  logic [SRC_W-1:0]  enq_source,
  input  logic [ADDR_W-1:0] enq_address,
  input  logic [7:0]        enq_mask,
  input  logic [63:0]       enq_data,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [2:0]        deq_opcode,
  output logic [2:0]        deq_param,
  output logic [2:0]        deq_size,
  output logic [SRC_W-1:0]  deq_source,
  output logic [ADDR_W-1:0] deq_address,
  output logic [7:0]        deq_mask,
  output logic [63:0]       deq_data,
  output logic              deq_last,
  output logic              full
);

  localparam int CNT_W = MAX_LGSIZE - 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  rem;
  logic [2:0]        saved_opcode;
  logic [2:0]        saved_param;
  logic [2:0]        saved_size;
  logic [SRC_W-1:0]  saved_source;
  logic [7:0]        saved_mask;
  logic [63:0]       saved_data;
  logic [ADDR_W-1:0] addr_q;

  logic              mb;
  logic [7:0]        span_m1;
  logic [CNT_W-1:0]  rem_init;
  logic [ADDR_W-1:0] enq_beat_addr;

  // Decode the incoming beat: multi-beat Get detection, replay count and beat-aligned address.
  always_comb begin
    mb            = (enq_opcode == 3'd4) && (enq_size > 3'd3);
    span_m1       = (8'd1 << (enq_size - 3'd3)) - 8'd1;
    // Oversized requests saturate the replay counter instead of wrapping it.
    rem_init      = (span_m1 > 8'(CNT_MAX)) ? CNT_MAX : span_m1[CNT_W-1:0];
    enq_beat_addr = {enq_address[ADDR_W-1:3], 3'b000};
  end

  // Capture a multi-beat Get on acceptance, then step address/counter on every replayed beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      full         <= 1'b0;
      rem          <= '0;
      saved_opcode <= '0;
      saved_param  <= '0;
      saved_size   <= '0;
      saved_source <= '0;
      saved_mask   <= '0;
      saved_data   <= '0;
      addr_q       <= '0;
    end else if (!full) begin
      if (enq_valid && enq_ready && mb) begin
        full         <= 1'b1;
        rem          <= rem_init;
        saved_opcode <= enq_opcode;
        saved_param  <= enq_param;
        saved_size   <= enq_size;
        saved_source <= enq_source;
        saved_mask   <= enq_mask;
        saved_data   <= enq_data;
        addr_q       <= enq_beat_addr + ADDR_W'(8);
      end
    end else if (deq_ready) begin
      rem    <= rem - CNT_W'(1);
      addr_q <= addr_q + ADDR_W'(8);
      if (rem == CNT_W'(1)) begin
        full <= 1'b0;
      end
    end
  end

  // Select pass-through or replay view of the beat; handshakes are squashed during reset.
  always_comb begin
    deq_opcode  = enq_opcode;
    deq_param   = enq_param;
    deq_size    = enq_size;
    deq_source  = enq_source;
    deq_address = mb ? enq_beat_addr : enq_address;
    deq_mask    = mb ? 8'hff : enq_mask;
    deq_data    = enq_data;
    deq_last    = !mb;
    deq_valid   = enq_valid && !reset;
    enq_ready   = deq_ready && !reset;
    if (full) begin
      deq_opcode  = saved_opcode;
      deq_param   = saved_param;
      deq_size    = saved_size;
      deq_source  = saved_source;
      deq_address = addr_q;
      deq_mask    = 8'hff;
      deq_data    = saved_data;
      deq_last    = (rem == CNT_W'(1));
      deq_valid   = !reset;
      enq_ready   = 1'b0;
    end
  end

endmodule

// File: tb/tb_tl_a_get_repeater.sv
// Testbench for tl_a_get_repeater: directed and randomized A-channel traffic.
// Expected beats come from a message-level model (beat count, address stride, mask rule).
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_tl_a_get_repeater;

  logic        clock;
  logic        reset;
  logic        enq_valid;
  logic        enq_ready;
  logic [2:0]  enq_opcode;
  logic [2:0]  enq_param;
  logic [2:0]  enq_size;
  logic [3:0]  enq_source;
  logic [31:0] enq_address;
  logic [7:0]  enq_mask;
  logic [63:0] enq_data;
  logic        deq_valid;
  logic        deq_ready;
  logic [2:0]  deq_opcode;
  logic [2:0]  deq_param;
  logic [2:0]  deq_size;
  logic [3:0]  deq_source;
  logic [31:0] deq_address;
  logic [7:0]  deq_mask;
  logic [63:0] deq_data;
  logic        deq_last;
  logic        full;

  int checks = 0;
  int errors = 0;

  tl_a_get_repeater #(.ADDR_W(32), .SRC_W(4), .MAX_LGSIZE(6)) dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_opcode(enq_opcode), .enq_param(enq_param), .enq_size(enq_size),
    .enq_source(enq_source), .enq_address(enq_address), .enq_mask(enq_mask),
    .enq_data(enq_data),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_opcode(deq_opcode), .deq_param(deq_param), .deq_size(deq_size),
    .deq_source(deq_source), .deq_address(deq_address), .deq_mask(deq_mask),
    .deq_data(deq_data), .deq_last(deq_last), .full(full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: how many beats a message occupies downstream.
  function automatic int model_beats(input logic [2:0] op, input logic [2:0] sz);
    if (op == 3'd4 && sz > 3'd3) return 1 << (int'(sz) - 3);
    return 1;
  endfunction

  // Reference model: address of beat k (8-byte stride from the truncated beat address, mod 2^32).
  function automatic logic [31:0] model_addr(input logic [2:0] op, input logic [2:0] sz,
                                             input logic [31:0] a, input int k);
    if (model_beats(op, sz) == 1 && !(op == 3'd4 && sz > 3'd3)) return a;
    return (a & ~32'h7) + 32'(8 * k);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives one message and follows every downstream beat, ready following pat bit by bit.
  task automatic run_msg(input string nm, input logic [2:0] op, input logic [2:0] sz,
                         input logic [31:0] a, input logic [7:0] m, input logic [63:0] d,
                         input logic [3:0] src, input logic [2:0] prm, input logic [31:0] pat);
    int n, k, cyc;
    logic mbx, fire, prev_stall;
    logic [31:0] ea;
    logic [7:0] em;
    logic [104:0] prev_out;
    n = model_beats(op, sz);
    mbx = (op == 3'd4 && sz > 3'd3);
    em = mbx ? 8'hff : m;
    enq_opcode = op; enq_size = sz; enq_address = a; enq_mask = m;
    enq_data = d; enq_source = src; enq_param = prm; enq_valid = 1'b1;
    k = 0; cyc = 0; prev_stall = 1'b0; prev_out = '0;
    while (k < n && cyc < 200) begin
      deq_ready = pat[cyc % 32];
      @(negedge clock);
      ea = model_addr(op, sz, a, k);
      checks++; if (deq_valid !== 1'b1) begin errors++; $display("FAIL %s valid beat %0d: got %b want 1", nm, k, deq_valid); end
      checks++; if (deq_address !== ea) begin errors++; $display("FAIL %s addr beat %0d: got %h want %h", nm, k, deq_address, ea); end
      checks++; if (deq_mask !== em) begin errors++; $display("FAIL %s mask beat %0d: got %h want %h", nm, k, deq_mask, em); end
      checks++; if (deq_last !== (k == n - 1)) begin errors++; $display("FAIL %s last beat %0d: got %b want %b", nm, k, deq_last, k == n - 1); end
      checks++; if (full !== (k > 0)) begin errors++; $display("FAIL %s full beat %0d: got %b want %b", nm, k, full, k > 0); end
      checks++; if (enq_ready !== (k == 0 && deq_ready)) begin errors++; $display("FAIL %s enq_ready beat %0d: got %b want %b", nm, k, enq_ready, k == 0 && deq_ready); end
      checks++; if ({deq_opcode, deq_param, deq_size, deq_source, deq_data} !== {op, prm, sz, src, d}) begin
        errors++; $display("FAIL %s fields beat %0d: got %h/%h want %h/%h", nm, k, deq_opcode, deq_data, op, d);
      end
      if (prev_stall) begin
        checks++;
        if ({deq_address, deq_mask, deq_data, full} !== prev_out) begin
          errors++; $display("FAIL %s stall hold beat %0d: got %h want %h", nm, k, {deq_address, deq_mask, deq_data, full}, prev_out);
        end
      end
      prev_stall = !deq_ready;
      prev_out = {deq_address, deq_mask, deq_data, full};
      fire = deq_ready;
      step();
      if (fire) begin
        if (k == 0) begin
          // Scramble the upstream bus so replays must come from the saved copy.
          enq_valid = 1'b0;
          enq_opcode = 3'($urandom); enq_size = 3'($urandom); enq_address = $urandom;
          enq_mask = 8'($urandom); enq_data = {$urandom, $urandom};
          enq_source = 4'($urandom); enq_param = 3'($urandom);
        end
        k++;
      end
      cyc++;
    end
    checks++; if (k != n) begin errors++; $display("FAIL %s beat count: got %0d want %0d (timeout)", nm, k, n); end
    deq_ready = 1'b1;
    @(negedge clock);
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL %s full after: got %b want 0", nm, full); end
    checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL %s idle valid after: got %b want 0", nm, deq_valid); end
  endtask

  task automatic test_reset();
    reset = 1'b1; enq_valid = 1'b1; deq_ready = 1'b1;
    enq_opcode = 3'd4; enq_size = 3'd6; enq_address = 32'h100; enq_mask = 8'h0f;
    enq_data = 64'h1; enq_source = 4'd1; enq_param = 3'd0;
    step(); step();
    @(negedge clock);
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL reset enq_ready: got %b want 0", enq_ready); end
    checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL reset deq_valid: got %b want 0", deq_valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset full: got %b want 0", full); end
    step();
    reset = 1'b0; enq_valid = 1'b0;
    @(negedge clock);
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL post-reset full: got %b want 0", full); end
    checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL post-reset deq_valid: got %b want 0", deq_valid); end
  endtask

  task automatic test_single_beat();
    step();
    run_msg("putfull", 3'd0, 3'd3, 32'h1000, 8'h0f, 64'hdead_beef_0123_4567, 4'd2, 3'd0, 32'hffff_ffff);
  endtask

  task automatic test_get64();
    step();
    run_msg("get64", 3'd4, 3'd6, 32'h2000, 8'hff, 64'h0, 4'd3, 3'd0, 32'hffff_ffff);
  endtask

  task automatic test_backpressure();
    step();
    // ready sequence 1,0,0,1,1,1 (LSB first)
    run_msg("backpressure", 3'd4, 3'd5, 32'h5500, 8'h3c, 64'h1111_2222_3333_4444, 4'd5, 3'd1, 32'hffff_fff9);
  endtask

  task automatic test_wrap();
    step();
    run_msg("wrap", 3'd4, 3'd5, 32'hffff_ffe0, 8'hff, 64'h0, 4'd7, 3'd0, 32'hffff_ffff);
  endtask

  task automatic test_reset_mid_replay();
    step();
    enq_opcode = 3'd4; enq_size = 3'd6; enq_address = 32'h3000; enq_mask = 8'hff;
    enq_data = 64'h0; enq_source = 4'd4; enq_param = 3'd0;
    enq_valid = 1'b1; deq_ready = 1'b1;
    step();
    enq_valid = 1'b0;
    step();
    @(negedge clock);
    checks++; if (deq_address !== 32'h3010 || full !== 1'b1) begin
      errors++; $display("FAIL midreset beat3: got %h/%b want 00003010/1", deq_address, full);
    end
    step();
    reset = 1'b1;
    enq_opcode = 3'd0; enq_size = 3'd3; enq_address = 32'h4000; enq_mask = 8'h0f;
    enq_data = 64'h55; enq_valid = 1'b1;
    @(negedge clock);
    checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL midreset deq_valid: got %b want 0", deq_valid); end
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL midreset enq_ready: got %b want 0", enq_ready); end
    step();
    reset = 1'b0;
    @(negedge clock);
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL midreset full after release: got %b want 0", full); end
    checks++; if (deq_valid !== 1'b1 || enq_ready !== 1'b1) begin
      errors++; $display("FAIL midreset passthrough hs: got %b%b want 11", deq_valid, enq_ready);
    end
    checks++; if (deq_address !== 32'h4000 || deq_mask !== 8'h0f || deq_last !== 1'b1) begin
      errors++; $display("FAIL midreset passthrough beat: got %h/%h/%b want 00004000/0f/1", deq_address, deq_mask, deq_last);
    end
    step();
    enq_valid = 1'b0;
    @(negedge clock);
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL midreset putfull full: got %b want 0", full); end
  endtask

  task automatic test_random();
    logic [2:0] op;
    for (int i = 0; i < 40; i++) begin
      step();
      op = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd4;
      run_msg("random", op, 3'($urandom_range(0, 6)), $urandom, 8'($urandom),
              {$urandom, $urandom}, 4'($urandom), 3'($urandom), $urandom | 32'h1111_1111);
    end
  endtask

  initial begin
    reset = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0;
    enq_opcode = '0; enq_param = '0; enq_size = '0; enq_source = '0;
    enq_address = '0; enq_mask = '0; enq_data = '0;
    test_reset();
    test_single_beat();
    test_get64();
    test_backpressure();
    test_wrap();
    test_reset_mid_replay();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
